sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Upstream neighbour of tt_um_sha256_shift_reg. It accepts a raw message as a byte stream and emits the FIPS 180-4 padded byte stream in 64-byte blocks: the data, then 0x80, then zero fill, then the 64-bit big-endian bit length. Its output feeds the core's serial byte-load path directly. One output register stage decouples it from the core's backpressure.

Parameters:
BYTE_CNT_W, 29, width of the message byte counter. Bit length = count<<3, zero-extended to 64 bits.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
in_data  in  8  message byte
in_valid  in  1  in_data/in_last/in_keep valid
in_keep  in  1  byte is part of the message; only meaningful with in_last (0 = terminator only, e.g. empty message)
in_last  in  1  final input beat of the message
in_ready  out  1  padder accepts an input beat this cycle
out_data  out  8  padded stream byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_block_last  out  1  out_data is byte 63 of a block
out_msg_last  out  1  out_data is the final length byte of the message

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous and active-low. On reset: out_valid=0, out_data=0, out_block_last=0, out_msg_last=0, state=DATA, pos=0, byte count=0, length index=0.
- Output register: loads whenever !out_valid || out_ready (advance). A transfer occurs when out_valid && out_ready. out_* are held stable while out_valid && !out_ready.
- in_ready = (state==DATA) && advance. Accept = in_valid && in_ready. Latency from accept to out_valid is 1 cycle.
- pos[5:0]: position in the current block of the next byte to be loaded. It increments on every output load and wraps 63→0.
- out_block_last is set on the load where pos==63.
- States:
  - DATA: on accept with in_keep=1 or in_last=0, load in_data and increment the byte count. If in_last, go to PAD80. On accept with in_last=1 and in_keep=0, load nothing and go to PAD80.
  - PAD80: on advance, load 0x80. If the loaded pos==55, go to LEN; otherwise go to ZERO.
  - ZERO: on advance, load 0x00. Leave for LEN after loading pos==55 (mod 64). If 0x80 landed at pos 56..63, zero-fill to 63, then 0..55 of the next block.
  - LEN: on advance, load length byte lidx (0..7, MSB first) of {zero-ext, count,3'b0}. At lidx==7, set out_msg_last=1, clear the count/lidx, and return to DATA. pos is 63 at that load by construction.
- in_ready is 0 outside DATA. Bytes presented there are not consumed and the upstream holds them.
- Byte count overflow beyond 2^BYTE_CNT_W−1 wraps modulo; there is no error flag.
- A new message may begin the cycle after out_msg_last is loaded. pos is 0 at that point.
- Reset mid-message discards everything, including a byte held in the output register. The downstream must also be reset.
- Zero-bubble: with out_ready held at 1, exactly one byte is loaded per cycle in PAD80/ZERO/LEN.

Decomposition:
- sha256_pkg holds:
  - BLOCK_BYTES=64
  - LEN_POS=56
  - PAD_BYTE=8'h80
  - LEN_BYTES=8
  - padder state enum {DATA, PAD80, ZERO, LEN}
- No sub-module needed; a single FSM with counters.

Test Plan:
- "abc" (61,62,63; last on 63), out_ready=1 → 64 bytes: 61 62 63 80, 52×00, 00×7, 18. out_block_last and out_msg_last on byte 63. Feeding this into the core gives digest ba7816bf…f20015ad.
- Empty message (single beat in_last=1, in_keep=0) → 80, 62×00, 00. Length field all zero, one block.
- 55-byte message → 0x80 at pos 55, length 0x01B8 at bytes 62..63, exactly one block.
- 56-byte message → 0x80 at pos 56, zeros to 63 (block_last, no msg_last), second block 56×00 + length 0x01C0. 128 bytes total.
- Random out_ready stalls (50%) on a 64-byte message → output sequence identical to the no-stall run. out_data stable during stalls; in_ready=0 whenever out_valid && !out_ready.
- rst_n pulsed low mid-ZERO (async, between clock edges) → out_valid=0 immediately. After release, "abc" pads correctly starting at pos 0.

Source files
------------

// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants, state type and length-byte helper for the SHA-256 message padder.
package sha256_pkg;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_POS     = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         LEN_BYTES   = 8;

    typedef enum logic [1:0] {
        DATA,
        PAD80,
        ZERO,
        LEN
    } pad_state_t;

    // Byte idx of the 64-bit length field, index 0 being the most significant byte.
    function automatic logic [7:0] len_byte(input logic [63:0] bit_len, input logic [2:0] idx);
        logic [5:0] shamt;
        shamt = {3'(3'd7 - idx), 3'b000};
        return 8'(bit_len >> shamt);
    endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Input message stream and padded output stream of the padder.
// Both streams: a beat transfers on a cycle where valid && ready; once valid is
// raised the producer holds data/flags stable until that transfer happens.
interface sha256_msg_padder_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_keep;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_block_last;
    logic       out_msg_last;

    modport master (
        input  in_data, in_valid, in_keep, in_last, out_ready,
        output in_ready, out_data, out_valid, out_block_last, out_msg_last
    );

    modport slave (
        output in_data, in_valid, in_keep, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_block_last, out_msg_last
    );

endinterface

// File: rtl/sha256_msg_padder.sv
// Pads a raw byte stream into FIPS 180-4 64-byte blocks behind one output register stage.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int BYTE_CNT_W = 29
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_msg_padder_if.master  bus,
    output pad_state_t           dbg_state
);

    localparam logic [5:0] LAST_ZERO_POS = 6'(LEN_POS - 1);
    localparam logic [5:0] BLOCK_END_POS = 6'(BLOCK_BYTES - 1);
    localparam logic [2:0] LAST_LIDX     = 3'(LEN_BYTES - 1);

    pad_state_t            state_q, state_d;
    logic [5:0]            pos_q;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            lidx_q, lidx_d;
    logic                  advance;
    logic                  load;
    logic [7:0]            load_data;
    logic                  msg_last_d;
    logic [63:0]           bit_len;

    // The output register may take a new byte when empty or being drained this cycle.
    assign advance   = !bus.out_valid || bus.out_ready;
    assign bit_len   = 64'({cnt_q, 3'b000});
    assign dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lidx_d       = lidx_q;
        load         = 1'b0;
        load_data    = 8'h00;
        msg_last_d   = 1'b0;
        bus.in_ready = (state_q == DATA) && advance;
        unique case (state_q)
            DATA: begin
                if (bus.in_valid && advance) begin
                    // A last beat with keep=0 only terminates the message.
                    if (bus.in_keep || !bus.in_last) begin
                        load      = 1'b1;
                        load_data = bus.in_data;
                        cnt_d     = cnt_q + 1'b1;
                    end
                    if (bus.in_last) state_d = PAD80;
                end
            end
            PAD80: begin
                if (advance) begin
                    load      = 1'b1;
                    load_data = PAD_BYTE;
                    state_d   = (pos_q == LAST_ZERO_POS) ? LEN : ZERO;
                end
            end
            ZERO: begin
                if (advance) begin
                    load = 1'b1;
                    if (pos_q == LAST_ZERO_POS) state_d = LEN;
                end
            end
            LEN: begin
                if (advance) begin
                    load      = 1'b1;
                    load_data = len_byte(bit_len, lidx_q);
                    lidx_d    = lidx_q + 1'b1;
                    if (lidx_q == LAST_LIDX) begin
                        msg_last_d = 1'b1;
                        cnt_d      = '0;
                        lidx_d     = '0;
                        state_d    = DATA;
                    end
                end
            end
            default: state_d = DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DATA;
            cnt_q   <= '0;
            lidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lidx_q  <= lidx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q              <= '0;
            bus.out_valid      <= 1'b0;
            bus.out_data       <= 8'h00;
            bus.out_block_last <= 1'b0;
            bus.out_msg_last   <= 1'b0;
        end else if (advance) begin
            bus.out_valid <= load;
            if (load) begin
                bus.out_data       <= load_data;
                bus.out_block_last <= (pos_q == BLOCK_END_POS);
                bus.out_msg_last   <= msg_last_d;
                pos_q              <= pos_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed and randomized checks of the padder against a queue-based padding model.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    pad_state_t dbg_state;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [9:0] exp_q[$];

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.BYTE_CNT_W(29)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected stream entries are {msg_last, block_last, data}.
    function automatic void build_expected(input logic [7:0] msg[$]);
        logic [7:0]  pad[$];
        logic [63:0] bits;
        int          n;
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bits = (64'(msg.size()) % (64'd1 << 29)) * 64'd8;
        for (int b = 7; b >= 0; b--) pad.push_back(bits[8*b +: 8]);
        n = pad.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), (i % 64 == 63), pad[i]});
    endfunction

    task automatic run_msg(input logic [7:0] msg[$], input int stall_pct, input int gap_pct,
                           input string name);
        int         nbeats;
        int         idx;
        int         cycles;
        bit         started;
        bit         prev_stall;
        logic [9:0] prev_out;
        logic [9:0] got;
        exp_q.delete();
        build_expected(msg);
        nbeats     = (msg.size() == 0) ? 1 : msg.size();
        idx        = 0;
        cycles     = 0;
        started    = 0;
        prev_stall = 0;
        prev_out   = '0;
        while (exp_q.size() > 0 && cycles < 2000) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(99) >= stall_pct);
            if (idx < nbeats && $urandom_range(99) >= gap_pct) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (msg.size() == 0) ? 8'($urandom) : msg[idx];
                bus.in_keep  = (msg.size() != 0);
                bus.in_last  = (idx == nbeats - 1);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_keep  = 1'($urandom);
                bus.in_last  = 1'($urandom);
            end
            #1;
            got = {bus.out_msg_last, bus.out_block_last, bus.out_data};
            if (cycles == 0) check({name, ":idle_at_start"}, 64'(bus.out_valid), 64'd0);
            if (prev_stall) begin
                check({name, ":held_valid"}, 64'(bus.out_valid), 64'd1);
                check({name, ":held_data"}, 64'(got), 64'(prev_out));
            end
            if (bus.out_valid && !bus.out_ready)
                check({name, ":in_ready_in_stall"}, 64'(bus.in_ready), 64'd0);
            if (started && stall_pct == 0 && gap_pct == 0)
                check({name, ":no_bubble"}, 64'(bus.out_valid), 64'd1);
            if (bus.out_valid) started = 1;
            if (bus.out_valid && bus.out_ready) check({name, ":stream"}, 64'(got), 64'(exp_q.pop_front()));
            if (bus.in_valid && bus.in_ready) idx++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = got;
            cycles++;
        end
        check({name, ":bytes_left"}, 64'(exp_q.size()), 64'd0);
        check({name, ":beats_taken"}, 64'(idx), 64'(nbeats));
        bus.in_valid = 1'b0;
    endtask

    function automatic void rand_msg(output logic [7:0] q[$], input int len);
        q.delete();
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] m[$];
        logic [7:0] abc[$];
        int         i;
        abc = '{8'h61, 8'h62, 8'h63};

        rst_n         = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_keep   = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst:out_valid", 64'(bus.out_valid), 64'd0);
        check("rst:out_data", 64'(bus.out_data), 64'd0);
        check("rst:block_last", 64'(bus.out_block_last), 64'd0);
        check("rst:msg_last", 64'(bus.out_msg_last), 64'd0);
        check("rst:state", 64'(dbg_state), 64'(DATA));
        check("rst:in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_msg(abc, 0, 0, "abc");
        m.delete();
        run_msg(m, 0, 0, "empty");
        rand_msg(m, 55);
        run_msg(m, 0, 0, "len55");
        rand_msg(m, 56);
        run_msg(m, 0, 0, "len56");
        rand_msg(m, 64);
        run_msg(m, 0, 0, "len64_nostall");
        run_msg(m, 50, 0, "len64_stall");
        for (int k = 0; k < 4; k++) begin
            rand_msg(m, $urandom_range(0, 130));
            run_msg(m, 30, 30, "rand_len");
        end

        // Abort an "abc" message once it is zero-filling, with reset between clock edges.
        i = 0;
        for (int c = 0; c < 40 && dbg_state != ZERO; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (i < 3);
            bus.in_data   = (i < 3) ? abc[i] : 8'h00;
            bus.in_keep   = 1'b1;
            bus.in_last   = (i == 2);
            #1;
            if (bus.in_valid && bus.in_ready) i++;
        end
        bus.in_valid = 1'b0;
        check("mid_rst:reached_zero", 64'(dbg_state), 64'(ZERO));
        check("mid_rst:valid_before", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst:out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst:out_data", 64'(bus.out_data), 64'd0);
        check("mid_rst:state", 64'(dbg_state), 64'(DATA));
        @(negedge clk);
        rst_n = 1'b1;
        run_msg(abc, 0, 0, "abc_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
